// File: rtl/lfsr_prng_pkg.sv
// Shared constants for the LFSR PRNG family.
// Holds the maximal-length tap masks and the collector FSM state encoding.
package lfsr_pkg;

    localparam logic [7:0]  TAP_8  = 8'hB8;
    localparam logic [15:0] TAP_16 = 16'hB400;
    localparam logic [31:0] TAP_32 = 32'h80200003;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

endpackage

// File: rtl/lfsr_prng_core.sv
// Fibonacci LFSR state register with feedback XOR, step enable and seed load.
// A zero seed is replaced by DEFAULT_SEED so the register can never lock up.
module lfsr_core import lfsr_pkg::*; #(
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  TAP_MASK     = TAP_16,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr,
    output logic             fb
);

    assign fb = ^(lfsr & TAP_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= DEFAULT_SEED;
        end else if (seed_load) begin
            lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
        end else if (step) begin
            lfsr <= {lfsr[WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised LFSR PRNG: packs OUT_W feedback bits per word onto a valid/ready stream.
// Optional macro LFSR_PERIOD_CNT_EN adds a step counter and the period_done pulse.
module lfsr_prng import lfsr_pkg::*; #(
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  TAP_MASK     = TAP_16,
    parameter int                OUT_W        = 8,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [WIDTH-1:0] lfsr,
    output logic             lockup_err
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic             period_done
`endif
);

    localparam int               CNT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT_W - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] collect;
    logic [OUT_W-1:0] word_next;
    logic             fb;
    logic             step;

    // In FULL a step is only allowed in the cycle the pending word is consumed.
    assign step      = !seed_load && en && ((state == COLLECT) || out_ready);
    assign word_next = (collect << 1) | OUT_W'(fb);
    assign out_valid = (state == FULL);

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAP_MASK     (TAP_MASK),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .seed_load (seed_load),
        .seed      (seed),
        .lfsr      (lfsr),
        .fb        (fb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            count      <= '0;
            collect    <= '0;
            out_data   <= '0;
            lockup_err <= 1'b0;
        end else if (seed_load) begin
            state      <= COLLECT;
            count      <= '0;
            lockup_err <= (seed == '0);
        end else if (step) begin
            collect <= word_next;
            // count is zero in FULL, so with OUT_W==1 a consume-plus-step refills immediately
            if (count == LAST) begin
                out_data <= word_next;
                count    <= '0;
                state    <= FULL;
            end else begin
                count <= count + 1'b1;
                state <= COLLECT;
            end
        end else if ((state == FULL) && out_ready) begin
            state <= COLLECT;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_cnt;

    // The period ends on the step whose next state equals the last loaded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_val    <= DEFAULT_SEED;
            step_cnt    <= '0;
            period_done <= 1'b0;
        end else if (seed_load) begin
            load_val    <= (seed == '0) ? DEFAULT_SEED : seed;
            step_cnt    <= '0;
            period_done <= 1'b0;
        end else if (step) begin
            if ({lfsr[WIDTH-2:0], fb} == load_val) begin
                period_done <= 1'b1;
                step_cnt    <= '0;
            end else begin
                period_done <= 1'b0;
                step_cnt    <= step_cnt + 1'b1;
            end
        end else begin
            period_done <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: table-driven vectors plus hand-written corner sequences.
// With LFSR_PERIOD_CNT_EN defined an 8-bit instance also checks the period_done pulse.
module tb_lfsr_prng;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        seed_load;
    logic [15:0] seed;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] lfsr;
    logic        lockup_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] seed;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [15:0] exp_lfsr;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

`ifdef LFSR_PERIOD_CNT_EN
    logic       main_done;
    logic       p_en = 1'b0;
    logic       p_ld = 1'b0;
    logic       p_valid;
    logic [7:0] p_data;
    logic [7:0] p_lfsr;
    logic       p_lock;
    logic       p_done;
`endif

    lfsr_prng #(
        .WIDTH        (16),
        .TAP_MASK     (16'hB400),
        .OUT_W        (8),
        .DEFAULT_SEED (16'h0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seed_load  (seed_load),
        .seed       (seed),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .lfsr       (lfsr),
        .lockup_err (lockup_err)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .period_done (main_done)
`endif
    );

`ifdef LFSR_PERIOD_CNT_EN
    lfsr_prng #(
        .WIDTH        (8),
        .TAP_MASK     (8'hB8),
        .OUT_W        (8),
        .DEFAULT_SEED (8'h01)
    ) dut8 (
        .clk         (clk),
        .rst         (rst),
        .en          (p_en),
        .seed_load   (p_ld),
        .seed        (8'h01),
        .out_ready   (1'b1),
        .out_valid   (p_valid),
        .out_data    (p_data),
        .lfsr        (p_lfsr),
        .lockup_err  (p_lock),
        .period_done (p_done)
    );
`endif

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic l, input logic [15:0] s, input logic r);
        en        = e;
        seed_load = l;
        seed      = s;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(input logic e, input logic l, input logic [15:0] s, input logic r,
                                    input logic v, input logic [7:0] d, input logic [15:0] q, input logic k);
        vec_t t;
        t.en = e; t.ld = l; t.seed = s; t.rdy = r;
        t.exp_valid = v; t.exp_data = d; t.exp_lfsr = q; t.exp_lock = k;
        vecs.push_back(t);
    endfunction

`ifdef LFSR_PERIOD_CNT_EN
    task automatic period_test();
        bit seen[256];
        int pulses[$];
        int dup;
        int visited;
        dup = 0;
        visited = 0;
        p_ld = 1'b1;
        @(posedge clk);
        #1;
        p_ld = 1'b0;
        p_en = 1'b1;
        for (int k = 1; k <= 520; k++) begin
            @(posedge clk);
            #1;
            if (p_done) pulses.push_back(k);
            if (k <= 255) begin
                if (seen[p_lfsr] || p_lfsr == 8'h00) dup++;
                else visited++;
                seen[p_lfsr] = 1'b1;
            end
        end
        p_en = 1'b0;
        check_output("period pulse count", pulses.size(), 2);
        check_output("period pulse 1", pulses[0], 255);
        check_output("period pulse 2", pulses[1], 510);
        check_output("period duplicate states", dup, 0);
        check_output("period visited states", visited, 255);
    endtask
`endif

    initial begin
        bit [7:0] words[$];
        int first_valid;

        rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset lfsr", lfsr, 16'h0001);
        check_output("reset valid", out_valid, 0);
        check_output("reset data", out_data, 0);
        check_output("reset lockup", lockup_err, 0);
        rst = 1'b0;

        add_vec(0, 1, 16'h0001, 1, 0, 8'h00, 16'h0001, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0002, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0004, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0008, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0010, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0020, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0040, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0080, 0);
        add_vec(1, 0, 16'h0000, 1, 1, 8'h00, 16'h0100, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0200, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0400, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h0801, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h1002, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h2005, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h400B, 0);
        add_vec(1, 0, 16'h0000, 1, 0, 8'h00, 16'h8016, 0);
        add_vec(1, 0, 16'h0000, 1, 1, 8'h2D, 16'h002D, 0);
        add_vec(1, 1, 16'h0000, 1, 0, 8'h2D, 16'h0001, 1);
        add_vec(0, 1, 16'hACE1, 1, 0, 8'h2D, 16'hACE1, 0);
        add_vec(0, 0, 16'h0000, 1, 0, 8'h2D, 16'hACE1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].en, vecs[i].ld, vecs[i].seed, vecs[i].rdy);
            check_output($sformatf("vec%0d valid", i), out_valid, vecs[i].exp_valid);
            check_output($sformatf("vec%0d data", i), out_data, vecs[i].exp_data);
            check_output($sformatf("vec%0d lfsr", i), lfsr, vecs[i].exp_lfsr);
            check_output($sformatf("vec%0d lockup", i), lockup_err, vecs[i].exp_lock);
        end

        // Backpressure: word held and LFSR frozen while out_ready is low.
        apply_stimulus(0, 1, 16'h0001, 0);
        repeat (8) apply_stimulus(1, 0, 16'h0000, 0);
        check_output("bp first valid", out_valid, 1);
        check_output("bp first data", out_data, 8'h00);
        for (int c = 0; c < 20; c++) begin
            apply_stimulus(1, 0, 16'h0000, 0);
            check_output($sformatf("bp hold valid c%0d", c), out_valid, 1);
            check_output($sformatf("bp hold data c%0d", c), out_data, 8'h00);
            check_output($sformatf("bp hold lfsr c%0d", c), lfsr, 16'h0100);
        end
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1, 0, 16'h0000, 1);
            if (c == 0) begin
                check_output("bp consume valid", out_valid, 0);
                check_output("bp consume lfsr", lfsr, 16'h0200);
            end
        end
        check_output("bp second valid", out_valid, 1);
        check_output("bp second data", out_data, 8'h2D);
        check_output("bp second lfsr", lfsr, 16'h002D);

        // Seed load while a word is pending discards it and restarts the count.
        apply_stimulus(1, 1, 16'h0001, 0);
        check_output("full load valid", out_valid, 0);
        check_output("full load lfsr", lfsr, 16'h0001);
        check_output("full load data", out_data, 8'h2D);
        repeat (7) apply_stimulus(1, 0, 16'h0000, 1);
        check_output("full load valid@7", out_valid, 0);
        check_output("full load lfsr@7", lfsr, 16'h0080);
        apply_stimulus(1, 0, 16'h0000, 1);
        check_output("full load valid@8", out_valid, 1);
        check_output("full load data@8", out_data, 8'h00);

        // Enable toggling: same words at half the rate.
        apply_stimulus(0, 1, 16'h0001, 1);
        first_valid = -1;
        for (int c = 0; c < 32; c++) begin
            apply_stimulus((c % 2) == 0, 0, 16'h0000, 1);
            if (out_valid) begin
                words.push_back(out_data);
                if (first_valid < 0) first_valid = c;
            end
        end
        check_output("toggle word count", words.size(), 2);
        check_output("toggle word0", words[0], 8'h00);
        check_output("toggle word1", words[1], 8'h2D);
        check_output("toggle first valid cycle", first_valid, 14);
        check_output("toggle final lfsr", lfsr, 16'h002D);

        // Asynchronous reset in the middle of a word.
        apply_stimulus(0, 1, 16'h0000, 1);
        check_output("zero seed lockup", lockup_err, 1);
        repeat (3) apply_stimulus(1, 0, 16'h0000, 1);
        check_output("pre-reset lfsr", lfsr, 16'h0008);
        #3;
        rst = 1'b1;
        #1;
        check_output("async rst lfsr", lfsr, 16'h0001);
        check_output("async rst data", out_data, 0);
        check_output("async rst valid", out_valid, 0);
        check_output("async rst lockup", lockup_err, 0);
        rst = 1'b0;
        repeat (7) apply_stimulus(1, 0, 16'h0000, 1);
        check_output("post rst valid@7", out_valid, 0);
        check_output("post rst lfsr@7", lfsr, 16'h0080);
        apply_stimulus(1, 0, 16'h0000, 1);
        check_output("post rst valid@8", out_valid, 1);
        check_output("post rst data@8", out_data, 8'h00);
        check_output("post rst lfsr@8", lfsr, 16'h0100);
        en = 1'b0;

`ifdef LFSR_PERIOD_CNT_EN
        period_test();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
